audio_i2s: RTL
==============

Name: audio_i2s

Overview:
- Downstream stage of the audio mixer. Takes the two 15-bit unsigned mixed channels (left/right) and serialises them to an external I2S DAC.
- Converts each channel to 16-bit signed, latches both channels together once per frame, and generates SCK/LRCK/SD from the system clock with an internal divider.
- Sits between the mixer outputs and the board audio pins.

Parameters:
- DIV, 8, system clocks per SCK half-period. Must be ≥1. SCK period = 2*DIV clocks; frame = 64*DIV clocks.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- left   in  15  unsigned mixed left sample, 0..32767
- right  in  15  unsigned mixed right sample, 0..32767
- sck    out  1  I2S bit clock
- lrck   out  1  I2S word select; 0 = left, 1 = right
- sd     out  1  I2S serial data, MSB first
- sample out  1  one-clock strobe when left/right are latched

Behaviour:
- Reset (reset=0 at a rising edge), all outputs and state cleared:
  - div=0, sck=0, slot=0, lrck=0, sd=0, sample=0, frame register=0.
- Divider:
  - div counts 0..DIV-1. At div==DIV-1 ("tick"), div←0 and sck toggles.
  - A tick with sck==1 is a falling-edge event (fall). A tick with sck==0 is a rise; no other action on a rise.
- Slot counter:
  - 5-bit slot advances by 1 on each fall and wraps 31→0.
  - lrck = 0 for slots 0..15 and 1 for slots 16..31. lrck is registered and changes on the fall that enters slot 0 or slot 16.
- Conversion, combinational before latching:
  - s16(x) = {~x[14], x[13:0], 1'b0}, i.e. (x − 16384) × 2 as two's complement.
  - Examples: 0→16'h8000, 16384→16'h0000, 32767→16'h7FFE.
- Latching:
  - On the fall that wraps slot 31→0: frame[31:0] ← {s16(left), s16(right)}, and sample=1 for that same clock only.
  - Inputs are sampled in that clock only; changes at other times are ignored until the next wrap.
- Serial data, registered, updated on every fall. Standard I2S, one-bit delay after lrck:
  - Entering slot k (1..31): sd ← frame[32−k]. Slot 1 carries the left MSB, slot 16 the left LSB, slot 17 the right MSB.
  - Entering slot 0: sd ← frame[0] (right LSB), using the frame value before the new latch takes effect.
- Timing:
  - sd and lrck change only on falls; the DAC samples them on SCK rising edges.
  - Input-to-pin latency: the left MSB appears 1 SCK period after the latch; the right LSB appears 32 SCK periods after it.
- After reset:
  - First rise after DIV clocks, first fall after 2*DIV clocks (slot 0→1).
  - The frame register is 0, so the first partial frame transmits zeros. The first real latch happens at the first 31→0 wrap, 64*DIV clocks after reset release.
- Reset mid-frame:
  - Aborts immediately to the reset state; no partial word is completed and sample is not asserted.
- No handshake with the mixer: it is free-running and its inputs are level signals.

Test Plan:
- Reset/idle, DIV=2: hold reset low 5 clocks, then release.
  - During reset: sck=lrck=sd=sample=0.
  - After release: first sck rise at clock 2, first fall at clock 4, and the sck period is 4 clocks.
- Conversion, DIV=2, left=15'h4000, right=15'h7FFF: after the first sample strobe, capture 32 bits across slots 1..31 plus the next slot 0.
  - Left word = 16'h0000, right word = 16'h7FFE.
- Extremes: left=0, right=15'h0001.
  - Left word = 16'h8000, right word = 16'h8002.
  - lrck=1 exactly during slots 16..31.
- Input stability: change left every 7 clocks with random values.
  - The transmitted left word always equals s16(left) at the clock sample=1.
  - The sample strobe occurs every 64*DIV clocks and lasts exactly 1 clock.
- Reset mid-frame: assert reset during slot 20 for 1 clock.
  - All outputs are 0 on the next clock.
  - The next sample strobe comes 64*DIV clocks after reset release.
- DIV=1: left=15'h7FFF, right=0.
  - sck toggles every clock.
  - Serialised words are 16'h7FFE and 16'h8000, with correct one-bit delay relative to lrck.

Source files
------------

// File: rtl/audio_i2s.sv
// audio_i2s: serialises two 15-bit unsigned mixer channels to an I2S DAC
//   clock  - system clock, rising edge
//   reset  - synchronous active-low reset
//   left   - unsigned left sample, latched once per frame
//   right  - unsigned right sample, latched once per frame
//   sck    - I2S bit clock, period 2*DIV system clocks
//   lrck   - word select, 0 = left, 1 = right
//   sd     - serial data, MSB first, one bit after lrck
//   sample - one-clock strobe when left/right are latched
module audio_i2s #(
   parameter int DIV = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [14:0] left,
   input  logic [14:0] right,
   output logic        sck,
   output logic        lrck,
   output logic        sd,
   output logic        sample
);
   localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
   logic [DW-1:0] div_q, div_d;
   logic [4:0] slot_q, slot_d;
   logic [31:0] frame_q, frame_d;
   logic sck_q, sck_d, lrck_q, lrck_d, sd_q, sd_d, sample_q, sample_d;
   logic tick, fall, wrap;
   always_comb begin
      tick = div_q == DW'(DIV - 1);
      fall = tick && sck_q;
      wrap = fall && slot_q == 5'd31;
      div_d = tick ? '0 : div_q + 1'b1;
      sck_d = sck_q ^ tick;
      slot_d = fall ? slot_q + 5'd1 : slot_q;
      lrck_d = fall ? slot_d[4] : lrck_q;
      // entering slot k transmits frame[(32-k) mod 32]; (32-(s+1)) mod 32 == ~s
      sd_d = fall ? frame_q[~slot_q] : sd_q;
      sample_d = wrap;
      // MSB inversion plus a zero LSB gives (x - 16384) * 2 in two's complement
      frame_d = wrap ? {~left[14], left[13:0], 1'b0, ~right[14], right[13:0], 1'b0} : frame_q;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         div_q <= '0;
         slot_q <= '0;
         frame_q <= '0;
         sck_q <= 1'b0;
         lrck_q <= 1'b0;
         sd_q <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         div_q <= div_d;
         slot_q <= slot_d;
         frame_q <= frame_d;
         sck_q <= sck_d;
         lrck_q <= lrck_d;
         sd_q <= sd_d;
         sample_q <= sample_d;
      end
   end
   assign sck = sck_q;
   assign lrck = lrck_q;
   assign sd = sd_q;
   assign sample = sample_q;
endmodule
